// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the memory port arbiter:
//               FSM state encoding, port owner encoding and latency limits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    // Largest supported memory read latency, in cycles
    localparam int MEM_LAT_MAX = 4;

    // Width of the WAIT-state down-counter (counts MEM_LAT-1 .. 0)
    localparam int LAT_CNT_W = $clog2(MEM_LAT_MAX);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_t;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Bundles the fetch port, the load/store port and the shared
//               memory port. "master" is the requester/memory side, "slave"
//               is the arbiter side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if;

    // Fetch port
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;

    // Load/store port
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;

    // Memory port
    logic [31:0] mem_addr;
    logic        mem_wr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output ls_req, ls_we, ls_addr, ls_wdata,
        input  ls_gnt, ls_rvalid, ls_rdata,
        input  mem_addr, mem_wr, mem_din,
        output mem_dout
    );

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  ls_req, ls_we, ls_addr, ls_wdata,
        output ls_gnt, ls_rvalid, ls_rdata,
        output mem_addr, mem_wr, mem_din,
        input  mem_dout
    );

endinterface

`default_nettype wire

// File: rtl/mem_arb_rr.sv
// ============================================================================
// Module      : mem_arb_rr
// Description : Two-way round-robin pick. A lone requester wins; on a tie the
//               port that did not own the last access wins.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic   if_req,
    input  logic   ls_req,
    input  owner_t last_owner,
    output owner_t winner
);

    // Winner selection; the result is ignored by the caller when nobody requests
    always_comb begin
        winner = OWN_IF;
        if (if_req && ls_req) begin
            winner = (last_owner == OWN_IF) ? OWN_LS : OWN_IF;
        end else if (ls_req) begin
            winner = OWN_LS;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-ported memory between a fetch port and a
//               load/store port. IDLE picks a winner, ISSUE drives the access
//               for one cycle, WAIT covers MEM_LAT read cycles, RESP returns
//               the completion pulse. All outputs are registered.
//               Optional build macro MEM_PORT_ARBITER_ALIGN_CHK_EN: requests
//               with addr[1:0] != 0 bypass the memory and complete with
//               rdata = 0 and an align_err pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT = 1   // legal range 1..MEM_LAT_MAX
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave bus,
    output logic              busy
`ifdef MEM_PORT_ARBITER_ALIGN_CHK_EN
    ,
    output logic              align_err
`endif
);

    state_t                 r_state;
    owner_t                 r_owner;
    owner_t                 r_last_owner;
    owner_t                 w_winner;
    logic                   r_we;
    logic [LAT_CNT_W-1:0]   r_wait_cnt;
    logic                   w_any_req;
    logic [31:0]            w_req_addr;
    logic [31:0]            w_req_wdata;
    logic                   w_req_we;

    assign w_any_req = bus.if_req | bus.ls_req;

    mem_arb_rr u_rr (
        .if_req     (bus.if_req),
        .ls_req     (bus.ls_req),
        .last_owner (r_last_owner),
        .winner     (w_winner)
    );

    // Mux the winning port's request fields; the fetch port never writes
    always_comb begin
        w_req_addr  = bus.if_addr;
        w_req_wdata = 32'd0;
        w_req_we    = 1'b0;
        if (w_winner == OWN_LS) begin
            w_req_addr  = bus.ls_addr;
            w_req_wdata = bus.ls_wdata;
            w_req_we    = bus.ls_we;
        end
    end

`ifdef MEM_PORT_ARBITER_ALIGN_CHK_EN
    logic w_misaligned;
    assign w_misaligned = |w_req_addr[1:0];
`endif

    // Arbitration FSM; pulse outputs default low every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_owner       <= OWN_IF;
            r_last_owner  <= OWN_LS;   // so the fetch port wins the first tie
            r_we          <= 1'b0;
            r_wait_cnt    <= '0;
            busy          <= 1'b0;
            bus.if_gnt    <= 1'b0;
            bus.if_rvalid <= 1'b0;
            bus.if_rdata  <= 32'd0;
            bus.ls_gnt    <= 1'b0;
            bus.ls_rvalid <= 1'b0;
            bus.ls_rdata  <= 32'd0;
            bus.mem_addr  <= 32'd0;
            bus.mem_wr    <= 1'b0;
            bus.mem_din   <= 32'd0;
`ifdef MEM_PORT_ARBITER_ALIGN_CHK_EN
            align_err     <= 1'b0;
`endif
        end else begin
            bus.if_gnt    <= 1'b0;
            bus.ls_gnt    <= 1'b0;
            bus.if_rvalid <= 1'b0;
            bus.ls_rvalid <= 1'b0;
            bus.mem_wr    <= 1'b0;
`ifdef MEM_PORT_ARBITER_ALIGN_CHK_EN
            align_err     <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_owner      <= w_winner;
                        r_we         <= w_req_we;
                        busy         <= 1'b1;
                        bus.mem_addr <= w_req_addr;
                        bus.mem_din  <= w_req_wdata;
`ifdef MEM_PORT_ARBITER_ALIGN_CHK_EN
                        if (w_misaligned) begin
                            r_state   <= ST_RESP;
                            align_err <= 1'b1;
                            if (w_winner == OWN_LS) begin
                                bus.ls_rvalid <= 1'b1;
                                bus.ls_rdata  <= 32'd0;
                            end else begin
                                bus.if_rvalid <= 1'b1;
                                bus.if_rdata  <= 32'd0;
                            end
                        end else
`endif
                        begin
                            r_state    <= ST_ISSUE;
                            bus.mem_wr <= w_req_we;
                            if (w_winner == OWN_LS) begin
                                bus.ls_gnt <= 1'b1;
                            end else begin
                                bus.if_gnt <= 1'b1;
                            end
                        end
                    end
                end

                ST_ISSUE: begin
                    if (r_we) begin
                        // Stores complete straight away with rdata forced to 0
                        r_state <= ST_RESP;
                        if (r_owner == OWN_LS) begin
                            bus.ls_rvalid <= 1'b1;
                            bus.ls_rdata  <= 32'd0;
                        end else begin
                            bus.if_rvalid <= 1'b1;
                            bus.if_rdata  <= 32'd0;
                        end
                    end else begin
                        r_state    <= ST_WAIT;
                        r_wait_cnt <= LAT_CNT_W'(MEM_LAT - 1);
                    end
                end

                ST_WAIT: begin
                    if (r_wait_cnt == '0) begin
                        r_state <= ST_RESP;
                        if (r_owner == OWN_LS) begin
                            bus.ls_rvalid <= 1'b1;
                            bus.ls_rdata  <= bus.mem_dout;
                        end else begin
                            bus.if_rvalid <= 1'b1;
                            bus.if_rdata  <= bus.mem_dout;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt - LAT_CNT_W'(1);
                    end
                end

                ST_RESP: begin
                    r_state      <= ST_IDLE;
                    r_last_owner <= r_owner;
                    busy         <= 1'b0;
                end

                default: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench. Two arbiters share clock and
//               reset: dut1 with MEM_LAT=1 and dut3 with MEM_LAT=3, each with
//               its own behavioural memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if bus1 ();
    mem_port_arbiter_if bus3 ();
    logic busy1;
    logic busy3;
`ifdef MEM_PORT_ARBITER_ALIGN_CHK_EN
    logic align_err1;
    logic align_err3;
`endif

    mem_port_arbiter #(.MEM_LAT(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1),
        .busy  (busy1)
`ifdef MEM_PORT_ARBITER_ALIGN_CHK_EN
        ,
        .align_err (align_err1)
`endif
    );

    mem_port_arbiter #(.MEM_LAT(3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3),
        .busy  (busy3)
`ifdef MEM_PORT_ARBITER_ALIGN_CHK_EN
        ,
        .align_err (align_err3)
`endif
    );

    // Memory for dut1: preloaded during reset, read data 1 cycle after address
    logic [31:0] mem1 [0:63];
    logic [31:0] pipe1;
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++)
                mem1[i] <= (i == 4) ? 32'hDEADBEEF : (32'hA500_0000 + 32'(i));
            pipe1 <= 32'd0;
        end else begin
            if (bus1.mem_wr) mem1[bus1.mem_addr[7:2]] <= bus1.mem_din;
            pipe1 <= mem1[bus1.mem_addr[7:2]];
        end
    end
    assign bus1.mem_dout = pipe1;

    // Memory for dut3: same contents, read data 3 cycles after address
    logic [31:0] mem3 [0:63];
    logic [31:0] pipe3 [0:2];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++)
                mem3[i] <= (i == 4) ? 32'hDEADBEEF : (32'hA500_0000 + 32'(i));
            for (int i = 0; i < 3; i++) pipe3[i] <= 32'd0;
        end else begin
            if (bus3.mem_wr) mem3[bus3.mem_addr[7:2]] <= bus3.mem_din;
            pipe3[0] <= mem3[bus3.mem_addr[7:2]];
            pipe3[1] <= pipe3[0];
            pipe3[2] <= pipe3[1];
        end
    end
    assign bus3.mem_dout = pipe3[2];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        bus1.if_req = 1'b0; bus1.if_addr = 32'd0;
        bus1.ls_req = 1'b0; bus1.ls_we = 1'b0; bus1.ls_addr = 32'd0; bus1.ls_wdata = 32'd0;
        bus3.if_req = 1'b0; bus3.if_addr = 32'd0;
        bus3.ls_req = 1'b0; bus3.ls_we = 1'b0; bus3.ls_addr = 32'd0; bus3.ls_wdata = 32'd0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        clear_inputs();
        repeat (3) tick();
        checks++;
        if ({busy1, bus1.if_gnt, bus1.ls_gnt, bus1.if_rvalid, bus1.ls_rvalid, bus1.mem_wr} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl1 got %b required 000000",
                     {busy1, bus1.if_gnt, bus1.ls_gnt, bus1.if_rvalid, bus1.ls_rvalid, bus1.mem_wr});
        end
        checks++;
        if ({bus1.mem_addr, bus1.mem_din, bus1.if_rdata, bus1.ls_rdata} !== 128'd0) begin
            errors++;
            $display("FAIL reset_data1 mem_addr=%h mem_din=%h if_rdata=%h ls_rdata=%h required all 0",
                     bus1.mem_addr, bus1.mem_din, bus1.if_rdata, bus1.ls_rdata);
        end
        checks++;
        if ({busy3, bus3.if_gnt, bus3.ls_gnt, bus3.if_rvalid, bus3.ls_rvalid, bus3.mem_wr} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl3 got %b required 000000",
                     {busy3, bus3.if_gnt, bus3.ls_gnt, bus3.if_rvalid, bus3.ls_rvalid, bus3.mem_wr});
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (busy1 !== 1'b0 || busy3 !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset busy1=%b busy3=%b required 0", busy1, busy3);
        end
    endtask

    task automatic test_fetch_read;
        bus1.if_addr = 32'h10;
        bus1.if_req  = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++;
            if (bus1.if_gnt !== (k == 1)) begin
                errors++;
                $display("FAIL fetch_gnt k=%0d got %b required %b", k, bus1.if_gnt, (k == 1));
            end
            checks++;
            if (bus1.if_rvalid !== (k == 3)) begin
                errors++;
                $display("FAIL fetch_rvalid k=%0d got %b required %b", k, bus1.if_rvalid, (k == 3));
            end
            checks++;
            if (busy1 !== (k <= 3)) begin
                errors++;
                $display("FAIL fetch_busy k=%0d got %b required %b", k, busy1, (k <= 3));
            end
            checks++;
            if (bus1.mem_wr !== 1'b0) begin
                errors++;
                $display("FAIL fetch_mem_wr k=%0d got %b required 0", k, bus1.mem_wr);
            end
            if (k == 1) begin
                checks++;
                if (bus1.mem_addr !== 32'h10) begin
                    errors++;
                    $display("FAIL fetch_mem_addr got %h required 00000010", bus1.mem_addr);
                end
                bus1.if_req = 1'b0;
            end
            if (k == 3) begin
                checks++;
                if (bus1.if_rdata !== 32'hDEADBEEF) begin
                    errors++;
                    $display("FAIL fetch_rdata got %h required deadbeef", bus1.if_rdata);
                end
            end
        end
    endtask

    task automatic test_store_load;
        bus1.ls_we    = 1'b1;
        bus1.ls_addr  = 32'h20;
        bus1.ls_wdata = 32'h12345678;
        bus1.ls_req   = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++;
            if (bus1.mem_wr !== (k == 1)) begin
                errors++;
                $display("FAIL store_mem_wr k=%0d got %b required %b", k, bus1.mem_wr, (k == 1));
            end
            checks++;
            if (bus1.ls_gnt !== (k == 1) || bus1.if_gnt !== 1'b0) begin
                errors++;
                $display("FAIL store_gnt k=%0d ls_gnt=%b if_gnt=%b required %b/0", k, bus1.ls_gnt, bus1.if_gnt, (k == 1));
            end
            checks++;
            if (bus1.ls_rvalid !== (k == 2)) begin
                errors++;
                $display("FAIL store_rvalid k=%0d got %b required %b", k, bus1.ls_rvalid, (k == 2));
            end
            if (k == 1) begin
                checks++;
                if (bus1.mem_addr !== 32'h20 || bus1.mem_din !== 32'h12345678) begin
                    errors++;
                    $display("FAIL store_bus addr=%h din=%h required 00000020/12345678", bus1.mem_addr, bus1.mem_din);
                end
                bus1.ls_req = 1'b0;
            end
            if (k == 2) begin
                checks++;
                if (bus1.ls_rdata !== 32'd0) begin
                    errors++;
                    $display("FAIL store_rdata got %h required 0", bus1.ls_rdata);
                end
            end
        end
        bus1.ls_we  = 1'b0;
        bus1.ls_req = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 1) bus1.ls_req = 1'b0;
            checks++;
            if (bus1.ls_rvalid !== (k == 3) || bus1.mem_wr !== 1'b0) begin
                errors++;
                $display("FAIL load_rvalid k=%0d rvalid=%b mem_wr=%b required %b/0", k, bus1.ls_rvalid, bus1.mem_wr, (k == 3));
            end
            if (k >= 3) begin
                checks++;
                if (bus1.ls_rdata !== 32'h12345678) begin
                    errors++;
                    $display("FAIL load_rdata k=%0d got %h required 12345678", k, bus1.ls_rdata);
                end
            end
        end
        checks++;
        if (bus1.if_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL if_rdata_hold got %h required deadbeef", bus1.if_rdata);
        end
    endtask

    task automatic test_round_robin;
        int got[4];
        int n   = 0;
        int cyc = 0;
        rst_n = 1'b0;
        clear_inputs();
        bus1.if_addr = 32'h10;
        bus1.ls_addr = 32'h20;
        bus1.if_req  = 1'b1;
        bus1.ls_req  = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        while (n < 4 && cyc < 40) begin
            tick();
            cyc++;
            checks++;
            if (bus1.if_gnt && bus1.ls_gnt) begin
                errors++;
                $display("FAIL rr_one_gnt cycle=%0d both gnt high required at most one", cyc);
            end
            if (bus1.if_gnt) begin
                got[n] = 0;
                n++;
            end else if (bus1.ls_gnt) begin
                got[n] = 1;
                n++;
            end
            if (bus1.ls_rvalid) begin
                checks++;
                if (bus1.ls_rdata !== 32'hA500_0008) begin
                    errors++;
                    $display("FAIL rr_ls_rdata got %h required a5000008", bus1.ls_rdata);
                end
            end
        end
        bus1.if_req = 1'b0;
        bus1.ls_req = 1'b0;
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL rr_timeout grants=%0d required 4 within 40 cycles", n);
        end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (got[i] != (i % 2)) begin
                errors++;
                $display("FAIL rr_order grant%0d got %s required %s", i,
                         (got[i] == 0) ? "IF" : "LS", ((i % 2) == 0) ? "IF" : "LS");
            end
        end
        cyc = 0;
        while (busy1 && cyc < 20) begin
            tick();
            cyc++;
        end
        checks++;
        if (busy1 !== 1'b0) begin
            errors++;
            $display("FAIL rr_drain busy1=%b required 0 within 20 cycles", busy1);
        end
        tick();
    endtask

    task automatic test_lat3;
        bus3.if_addr = 32'h10;
        bus3.if_req  = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            checks++;
            if (bus3.if_gnt !== (k == 1)) begin
                errors++;
                $display("FAIL lat3_gnt k=%0d got %b required %b", k, bus3.if_gnt, (k == 1));
            end
            if (k == 1) bus3.if_req = 1'b0;
            checks++;
            if (bus3.if_rvalid !== (k == 5)) begin
                errors++;
                $display("FAIL lat3_rvalid k=%0d got %b required %b", k, bus3.if_rvalid, (k == 5));
            end
            checks++;
            if (busy3 !== (k <= 5) || bus3.mem_wr !== 1'b0) begin
                errors++;
                $display("FAIL lat3_busy k=%0d busy=%b mem_wr=%b required %b/0", k, busy3, bus3.mem_wr, (k <= 5));
            end
            if (k <= 4) begin
                checks++;
                if (bus3.mem_addr !== 32'h10) begin
                    errors++;
                    $display("FAIL lat3_addr_hold k=%0d got %h required 00000010", k, bus3.mem_addr);
                end
            end
            if (k == 5) begin
                checks++;
                if (bus3.if_rdata !== 32'hDEADBEEF) begin
                    errors++;
                    $display("FAIL lat3_rdata got %h required deadbeef", bus3.if_rdata);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        logic seen = 1'b0;
        bus3.ls_we   = 1'b0;
        bus3.ls_addr = 32'h20;
        bus3.ls_req  = 1'b1;
        tick();
        checks++;
        if (bus3.ls_gnt !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_gnt got %b required 1", bus3.ls_gnt);
        end
        bus3.ls_req = 1'b0;
        tick();
        checks++;
        if (busy3 !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_in_wait busy=%b required 1", busy3);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy3, bus3.mem_wr, bus3.if_gnt, bus3.ls_gnt, bus3.if_rvalid, bus3.ls_rvalid} !== 6'b0) begin
            errors++;
            $display("FAIL rstmid_async got %b required 000000",
                     {busy3, bus3.mem_wr, bus3.if_gnt, bus3.ls_gnt, bus3.if_rvalid, bus3.ls_rvalid});
        end
        repeat (2) tick();
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (busy3 || bus3.mem_wr || bus3.if_gnt || bus3.ls_gnt || bus3.if_rvalid || bus3.ls_rvalid)
                seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_dropped activity=%b required 0 after release", seen);
        end
    endtask

`ifdef MEM_PORT_ARBITER_ALIGN_CHK_EN
    task automatic test_align;
        bus1.ls_we    = 1'b1;
        bus1.ls_addr  = 32'h22;
        bus1.ls_wdata = 32'h55;
        bus1.ls_req   = 1'b1;
        tick();
        bus1.ls_req = 1'b0;
        checks++;
        if (bus1.ls_rvalid !== 1'b1 || align_err1 !== 1'b1) begin
            errors++;
            $display("FAIL align_resp rvalid=%b align_err=%b required 1/1", bus1.ls_rvalid, align_err1);
        end
        checks++;
        if (bus1.mem_wr !== 1'b0 || bus1.ls_gnt !== 1'b0 || bus1.ls_rdata !== 32'd0) begin
            errors++;
            $display("FAIL align_nowr mem_wr=%b gnt=%b rdata=%h required 0/0/0", bus1.mem_wr, bus1.ls_gnt, bus1.ls_rdata);
        end
        tick();
        checks++;
        if (align_err1 !== 1'b0 || bus1.mem_wr !== 1'b0 || bus1.ls_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL align_after align_err=%b mem_wr=%b rvalid=%b required 0/0/0", align_err1, bus1.mem_wr, bus1.ls_rvalid);
        end
        tick();
        checks++;
        if (busy1 !== 1'b0) begin
            errors++;
            $display("FAIL align_idle busy=%b required 0", busy1);
        end
        bus1.ls_we = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fetch_read();
        test_store_load();
        test_round_robin();
        test_lat3();
        test_reset_mid();
`ifdef MEM_PORT_ARBITER_ALIGN_CHK_EN
        test_align();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 1: memory read latency in cycles, legal range 1..4.
REQ-002 clock  in  1  system clock; all state changes on its rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 if_req  in  1  fetch request; level, held until if_gnt.
REQ-005 if_addr  in  32  fetch byte address; stable while if_req=1.
REQ-006 if_gnt  out  1  one-cycle pulse when the fetch is issued.
REQ-007 if_rvalid  out  1  one-cycle pulse when if_rdata is valid.
REQ-008 if_rdata  out  32  fetched word.
REQ-009 ls_req  in  1  load/store request; level, held until ls_gnt.
REQ-010 ls_we  in  1  1=store, 0=load; stable while ls_req=1.
REQ-011 ls_addr  in  32  load/store byte address.
REQ-012 ls_wdata  in  32  store data.
REQ-013 ls_gnt  out  1  one-cycle issue pulse.
REQ-014 ls_rvalid  out  1  one-cycle completion pulse for both loads and stores.
REQ-015 ls_rdata  out  32  loaded word; 0 for stores.
REQ-016 mem_addr  out  32  memory address.
REQ-017 mem_wr  out  1  memory write strobe.
REQ-018 mem_din  out  32  memory write data.
REQ-019 mem_dout  in  32  memory read data, valid MEM_LAT cycles after the address is applied.
REQ-020 busy  out  1  high in every state except IDLE.

Function
REQ-021 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP.
REQ-022 IDLE, any request: the FSM SHALL pick the winner, latch its addr/we/wdata and go to ISSUE.
REQ-023 Arbitration: a single requester wins; if both request, the winner SHALL be the requester that did not win last (last_owner register).
REQ-024 ISSUE (1 cycle): mem_addr SHALL be the latched address, mem_wr SHALL equal the latched we, mem_din SHALL be the latched wdata, and the winner's gnt SHALL pulse.
REQ-025 ISSUE then goes to RESP for a store, or to WAIT for a read.
REQ-026 WAIT: mem_addr SHALL be held and mem_wr SHALL be 0 for MEM_LAT cycles, then mem_dout is captured into the winner's rdata register and the FSM goes to RESP.
REQ-027 RESP (1 cycle): the winner's rvalid SHALL pulse, last_owner SHALL update, and the FSM SHALL return to IDLE.
REQ-028 Latency, request first seen in IDLE at cycle t: gnt at t+1; rvalid at t+2 for a store and at t+2+MEM_LAT for a read.
REQ-029 The rdata outputs SHALL hold their value until the next completion for the same port.
REQ-030 Requests arriving while busy=1 SHALL wait, and no request SHALL be dropped.
REQ-031 A requester that keeps req asserted after gnt SHALL be treated as a new request.
REQ-032 mem_wr SHALL be high only in ISSUE with a latched store; at most one gnt is high per cycle.

Reset
REQ-033 reset=0 SHALL immediately force IDLE, all outputs to 0 and last_owner to LS, so IF wins the first tie.
REQ-034 Reset mid-access SHALL drop the access with no gnt, rvalid or mem_wr afterwards.

Configuration
REQ-035 With MEM_PORT_ARBITER_ALIGN_CHK_EN defined, a request with addr[1:0]!=0 SHALL skip ISSUE/WAIT and go to RESP with rdata=0.
REQ-036 In that case mem_wr SHALL stay 0 and an extra output align_err (1 bit) SHALL pulse together with rvalid.
REQ-037 With MEM_PORT_ARBITER_ALIGN_CHK_EN undefined, the align_err port SHALL be absent and misaligned addresses SHALL pass through unchanged.

Structure
REQ-038 Package mem_arb_pkg SHALL hold the state enum, the owner enum (OWN_IF, OWN_LS) and MEM_LAT_MAX=4.
REQ-039 The round-robin pick logic SHALL be the sub-module mem_arb_rr (inputs: two reqs and last_owner; output: winner).

Verification
REQ-040 Fetch-only read, MEM_LAT=1, if_addr=0x10, memory word 0xDEADBEEF -> if_gnt at t+1, if_rvalid at t+3, if_rdata=0xDEADBEEF.
REQ-041 Store ls_addr=0x20, ls_wdata=0x12345678 -> mem_wr=1 for exactly one cycle at t+1 and ls_rvalid at t+2; a later load from 0x20 returns 0x12345678.
REQ-042 if_req and ls_req both held high from reset release -> grant order IF, LS, IF, LS.
REQ-043 MEM_LAT=3 read -> mem_addr held for 4 cycles and rvalid at t+5.
REQ-044 reset asserted during WAIT -> busy, mem_wr and all gnt/rvalid outputs are 0 immediately; no rvalid after release.
REQ-045 With MEM_PORT_ARBITER_ALIGN_CHK_EN defined, ls_addr=0x22 store -> no mem_wr, and ls_rvalid plus align_err at t+1.
